// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_predictor                                                         |
// | Direct-mapped BTB with 2-bit direction counters and static BTFN fallback.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 16,
    parameter int MODE     = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [63:0]      lookup_pc,
    input  logic [63:0]      pcjump,
    input  logic [63:0]      pcplus4,
    output logic [63:0]      predPC,
    output logic             pred_taken,
    output logic             pred_hit,
    input  logic             upd_valid,
    input  logic [63:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [63:0]      upd_target,
    input  logic             upd_mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int               IDX         = $clog2(ENTRIES);
    localparam bit               c_dynamic   = (MODE == 1);
    localparam logic [63:0]      c_no_branch = '1;
    localparam logic [CNT_W-1:0] c_cnt_one   = 1;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [63:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [CNT_W-1:0]    r_cnt;

    logic [IDX-1:0]      w_lk_idx;
    logic [IDX-1:0]      w_up_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic [TAG_BITS-1:0] w_up_tag;
    logic                w_lk_hit;
    logic                w_up_hit;
    logic                w_static_taken;
    logic                w_wr_en;
    logic [1:0]          w_ctr_next;
    logic                w_unused;

    assign w_lk_idx = lookup_pc[IDX+1:2];
    assign w_lk_tag = lookup_pc[IDX+TAG_BITS+1:IDX+2];
    assign w_up_idx = upd_pc[IDX+1:2];
    assign w_up_tag = upd_pc[IDX+TAG_BITS+1:IDX+2];

    // PC bits outside the index/tag window do not take part in matching
    assign w_unused = ^{lookup_pc[63:IDX+TAG_BITS+2], lookup_pc[1:0],
                        upd_pc[63:IDX+TAG_BITS+2], upd_pc[1:0]};

    assign w_lk_hit = c_dynamic && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = c_dynamic && r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign w_static_taken = (pcjump != c_no_branch) && (pcjump < pcplus4);

    always_comb begin
        predPC     = pcplus4;
        pred_taken = 1'b0;
        pred_hit   = w_lk_hit;
        if (w_lk_hit && r_ctr[w_lk_idx][1]) begin
            predPC     = r_target[w_lk_idx];
            pred_taken = 1'b1;
        end else if (w_static_taken) begin
            predPC     = pcjump;
            pred_taken = 1'b1;
        end
    end

    // Write on a hit (train) or on a taken miss (allocate over any alias)
    assign w_wr_en = c_dynamic && upd_valid && (w_up_hit || upd_taken);

    always_comb begin
        w_ctr_next = 2'b10;
        if (w_up_hit) begin
            if (upd_taken)
                w_ctr_next = (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
            else
                w_ctr_next = (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= 2'b01;
        end else if (w_wr_en) begin
            r_valid[w_up_idx] <= 1'b1;
            r_ctr[w_up_idx]   <= w_ctr_next;
        end
    end

    // Tags and targets are qualified by the valid bit, so they need no reset
    always_ff @(posedge clk) begin
        if (w_wr_en && upd_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_cnt <= '0;
        else if (upd_valid && upd_mispredict && (r_cnt != '1))
            r_cnt <= r_cnt + c_cnt_one;
    end

    assign mispredict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_predictor                                                      |
// | Self-checking bench: dynamic, 4-bit-counter and static-only instances.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_branch_predictor;

    localparam int          c_ent  = 64;
    localparam logic [63:0] c_ones = '1;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] lookup_pc, pcjump, pcplus4, upd_pc, upd_target;
    logic        upd_valid, upd_taken, upd_mispredict;

    logic [63:0] d_pc, c_pc, s_pc;
    logic        d_tk, d_hit, c_tk, c_hit, s_tk, s_hit;
    logic [31:0] d_cnt, s_cnt;
    logic [3:0]  c_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the table as plain arrays, indexed by arithmetic on the PC
    bit              m_valid [c_ent];
    logic [15:0]     m_tag   [c_ent];
    logic [63:0]     m_tgt   [c_ent];
    int              m_ctr   [c_ent];
    longint unsigned m_cnt;
    int              m_cnt4;

    always #5 clk = ~clk;

    branch_predictor u_dut (
        .clk(clk), .resetn(resetn), .lookup_pc(lookup_pc), .pcjump(pcjump), .pcplus4(pcplus4),
        .predPC(d_pc), .pred_taken(d_tk), .pred_hit(d_hit), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .mispredict_cnt(d_cnt)
    );

    branch_predictor #(.CNT_W(4)) u_cnt4 (
        .clk(clk), .resetn(resetn), .lookup_pc(lookup_pc), .pcjump(pcjump), .pcplus4(pcplus4),
        .predPC(c_pc), .pred_taken(c_tk), .pred_hit(c_hit), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .mispredict_cnt(c_cnt)
    );

    branch_predictor #(.MODE(0)) u_static (
        .clk(clk), .resetn(resetn), .lookup_pc(lookup_pc), .pcjump(pcjump), .pcplus4(pcplus4),
        .predPC(s_pc), .pred_taken(s_tk), .pred_hit(s_hit), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .mispredict_cnt(s_cnt)
    );

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc / 64'd4) % 64'(c_ent));
    endfunction

    function automatic logic [15:0] tag_of(input logic [63:0] pc);
        return 16'((pc / 64'd256) % 64'd65536);
    endfunction

    function automatic void static_pred(input logic [63:0] jmp, input logic [63:0] p4,
                                        output logic [63:0] pp, output logic tk);
        tk = (jmp != c_ones) && (jmp < p4);
        pp = tk ? jmp : p4;
    endfunction

    function automatic void dyn_pred(input logic [63:0] pc, input logic [63:0] jmp,
                                     input logic [63:0] p4, output logic [63:0] pp,
                                     output logic tk, output logic hit);
        int i = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (hit && m_ctr[i] >= 2) begin
            pp = m_tgt[i];
            tk = 1'b1;
        end else begin
            static_pred(jmp, p4, pp, tk);
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < c_ent; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    task automatic model_update();
        int i;
        if (!upd_valid) return;
        if (upd_mispredict) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        i = idx_of(upd_pc);
        if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
            if (upd_taken) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_tgt[i] = upd_target;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = 2;
        end
    endtask

    task automatic set_lookup(input logic [63:0] pc, input logic [63:0] jmp);
        lookup_pc = pc;
        pcjump    = jmp;
        pcplus4   = pc + 64'd4;
    endtask

    task automatic set_upd(input logic v, input logic [63:0] pc, input logic tk,
                           input logic [63:0] tgt, input logic mp);
        upd_valid      = v;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    // Advance one clock; the model absorbs the update the DUT sampled on this edge
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn    = 1'b0;
        upd_valid = 1'b0;
        model_clear();
        #2;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        model_clear();
        set_lookup(64'h1000, c_ones);
        #2;
        n_vec++;
        if ({d_pc, d_tk, d_hit} !== {64'h1004, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_lookup: got pc=%h tk=%b hit=%b, want pc=1004 tk=0 hit=0", d_pc, d_tk, d_hit);
        end
        n_vec++;
        if ({d_cnt, c_cnt, s_cnt} !== 68'h0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d, want 0/0/0", d_cnt, c_cnt, s_cnt);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_static();
        do_reset();
        set_lookup(64'h2000, 64'h1F00);
        #1;
        n_vec++;
        if ({d_pc, d_tk, d_hit} !== {64'h1F00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL static_backward: got pc=%h tk=%b hit=%b, want pc=1f00 tk=1 hit=0", d_pc, d_tk, d_hit);
        end
        set_lookup(64'h2000, 64'h3000);
        #1;
        n_vec++;
        if ({d_pc, d_tk, d_hit} !== {64'h2004, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL static_forward: got pc=%h tk=%b hit=%b, want pc=2004 tk=0 hit=0", d_pc, d_tk, d_hit);
        end
        set_lookup(64'h2000, 64'h2004);
        #1;
        n_vec++;
        if ({d_pc, d_tk} !== {64'h2004, 1'b0}) begin
            n_bad++;
            $display("FAIL static_equal: got pc=%h tk=%b, want pc=2004 tk=0", d_pc, d_tk);
        end
    endtask

    task automatic test_counter();
        do_reset();
        set_upd(1'b1, 64'h2000, 1'b1, 64'h8000, 1'b0);
        tick();
        set_lookup(64'h2000, c_ones);
        #1;
        n_vec++;
        if ({d_pc, d_tk, d_hit} !== {64'h8000, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL alloc_hit: got pc=%h tk=%b hit=%b, want pc=8000 tk=1 hit=1", d_pc, d_tk, d_hit);
        end
        set_upd(1'b1, 64'h2000, 1'b0, 64'h0, 1'b1);
        tick();
        #1;
        n_vec++;
        if ({d_pc, d_tk, d_hit} !== {64'h2004, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL ctr_01: got pc=%h tk=%b hit=%b, want pc=2004 tk=0 hit=1", d_pc, d_tk, d_hit);
        end
        set_upd(1'b1, 64'h2000, 1'b0, 64'h0, 1'b1);
        tick();
        set_lookup(64'h2000, 64'h1F00);
        #1;
        n_vec++;
        if ({d_pc, d_tk, d_hit} !== {64'h1F00, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL ctr_00_static: got pc=%h tk=%b hit=%b, want pc=1f00 tk=1 hit=1", d_pc, d_tk, d_hit);
        end
        for (int k = 0; k < 4; k++) begin
            set_upd(1'b1, 64'h2000, 1'b1, 64'h8000, 1'b0);
            tick();
        end
        set_upd(1'b1, 64'h2000, 1'b0, 64'h0, 1'b0);
        tick();
        set_lookup(64'h2000, c_ones);
        #1;
        n_vec++;
        if ({d_pc, d_tk, d_hit} !== {64'h8000, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL ctr_saturate: got pc=%h tk=%b hit=%b, want pc=8000 tk=1 hit=1", d_pc, d_tk, d_hit);
        end
        n_vec++;
        if (d_cnt !== 32'd2) begin
            n_bad++;
            $display("FAIL cnt_after_counter: got %0d, want 2", d_cnt);
        end
    endtask

    task automatic test_same_cycle_alias();
        do_reset();
        set_upd(1'b1, 64'h2000, 1'b1, 64'h9000, 1'b0);
        set_lookup(64'h2000, c_ones);
        #1;
        n_vec++;
        if (d_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL same_cycle_nobypass: got hit=%b, want 0", d_hit);
        end
        tick();
        #1;
        n_vec++;
        if ({d_pc, d_hit} !== {64'h9000, 1'b1}) begin
            n_bad++;
            $display("FAIL next_cycle_hit: got pc=%h hit=%b, want pc=9000 hit=1", d_pc, d_hit);
        end
        set_upd(1'b1, 64'h2000 + 64'(4 * c_ent), 1'b1, 64'hA000, 1'b0);
        tick();
        #1;
        n_vec++;
        if ({d_pc, d_hit} !== {64'h2004, 1'b0}) begin
            n_bad++;
            $display("FAIL alias_evicts: got pc=%h hit=%b, want pc=2004 hit=0", d_pc, d_hit);
        end
        set_lookup(64'h2000 + 64'(4 * c_ent), c_ones);
        #1;
        n_vec++;
        if ({d_pc, d_hit} !== {64'hA000, 1'b1}) begin
            n_bad++;
            $display("FAIL alias_hit: got pc=%h hit=%b, want pc=a000 hit=1", d_pc, d_hit);
        end
    endtask

    task automatic test_mispredict_sat();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            set_upd(1'b1, 64'h7000, 1'b0, 64'h0, 1'b1);
            tick();
            if (k == 15 || k == 17) begin
                n_vec++;
                if (c_cnt !== 4'd15) begin
                    n_bad++;
                    $display("FAIL cnt4_sat_%0d: got %0d, want 15", k, c_cnt);
                end
            end
        end
        n_vec++;
        if ({d_cnt, s_cnt} !== {32'd17, 32'd17}) begin
            n_bad++;
            $display("FAIL cnt32_17: got %0d/%0d, want 17/17", d_cnt, s_cnt);
        end
    endtask

    task automatic test_async_reset();
        set_upd(1'b1, 64'h3000, 1'b1, 64'hB000, 1'b1);
        tick();
        set_lookup(64'h3000, c_ones);
        #1;
        n_vec++;
        if ({d_pc, d_hit} !== {64'hB000, 1'b1}) begin
            n_bad++;
            $display("FAIL pre_reset_hit: got pc=%h hit=%b, want pc=b000 hit=1", d_pc, d_hit);
        end
        #1;
        resetn = 1'b0;
        model_clear();
        #1;
        n_vec++;
        if ({d_pc, d_tk, d_hit, c_hit} !== {64'h3004, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset_hit: got pc=%h tk=%b hit=%b/%b, want pc=3004 tk=0 hit=0/0", d_pc, d_tk, d_hit, c_hit);
        end
        n_vec++;
        if ({d_cnt, c_cnt, s_cnt} !== 68'h0) begin
            n_bad++;
            $display("FAIL async_reset_cnt: got %0d/%0d/%0d, want 0/0/0", d_cnt, c_cnt, s_cnt);
        end
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_static_mode();
        logic [63:0] e_pc;
        logic        e_tk;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_upd(1'b1, 64'h2000, 1'b1, 64'h8000, 1'b1);
            tick();
        end
        set_lookup(64'h2000, 64'h1F00);
        #1;
        static_pred(pcjump, pcplus4, e_pc, e_tk);
        n_vec++;
        if ({s_pc, s_tk, s_hit} !== {e_pc, e_tk, 1'b0}) begin
            n_bad++;
            $display("FAIL mode0_static: got pc=%h tk=%b hit=%b, want pc=%h tk=%b hit=0", s_pc, s_tk, s_hit, e_pc, e_tk);
        end
        set_lookup(64'h2000, c_ones);
        #1;
        n_vec++;
        if ({s_pc, s_tk, s_hit} !== {64'h2004, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mode0_nohit: got pc=%h tk=%b hit=%b, want pc=2004 tk=0 hit=0", s_pc, s_tk, s_hit);
        end
        n_vec++;
        if (s_cnt !== 32'd4) begin
            n_bad++;
            $display("FAIL mode0_cnt: got %0d, want 4", s_cnt);
        end
    endtask

    task automatic test_random();
        logic [63:0] e_pc, sp, pc, tgt;
        logic        e_tk, e_hit, st;
        for (int n = 0; n < 400; n++) begin
            // Small PC pool: 8 indices x 3 tags, with don't-care high bits toggled
            pc = 64'h4000 + 64'($urandom_range(0, 7)) * 4 + 64'($urandom_range(0, 2)) * 256
                 + (($urandom_range(0, 1) == 1) ? 64'h100_0000_0000 : 64'h0);
            tgt = {32'h0, $urandom} & ~64'h3;
            set_upd($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1, tgt,
                    $urandom_range(0, 1) == 1);
            pc = 64'h4000 + 64'($urandom_range(0, 7)) * 4 + 64'($urandom_range(0, 2)) * 256;
            case ($urandom_range(0, 4))
                0: set_lookup(pc, c_ones);
                1: set_lookup(pc, pc + 64'd4 - 64'($urandom_range(1, 256)));
                2: set_lookup(pc, pc + 64'd4 + 64'($urandom_range(1, 256)));
                3: set_lookup(pc, pc + 64'd4);
                default: set_lookup(pc, pc);
            endcase
            #1;
            dyn_pred(lookup_pc, pcjump, pcplus4, e_pc, e_tk, e_hit);
            static_pred(pcjump, pcplus4, sp, st);
            n_vec++;
            if ({d_pc, d_tk, d_hit, c_pc, c_tk, c_hit} !== {e_pc, e_tk, e_hit, e_pc, e_tk, e_hit}) begin
                n_bad++;
                $display("FAIL rand_dyn[%0d]: pc=%h got %h/%b/%b, want %h/%b/%b", n, lookup_pc, d_pc, d_tk, d_hit, e_pc, e_tk, e_hit);
            end
            n_vec++;
            if ({s_pc, s_tk, s_hit} !== {sp, st, 1'b0}) begin
                n_bad++;
                $display("FAIL rand_mode0[%0d]: got %h/%b/%b, want %h/%b/0", n, s_pc, s_tk, s_hit, sp, st);
            end
            n_vec++;
            if ({d_cnt, s_cnt, c_cnt} !== {m_cnt[31:0], m_cnt[31:0], 4'(m_cnt4)}) begin
                n_bad++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d/%0d, want %0d/%0d/%0d", n, d_cnt, s_cnt, c_cnt, m_cnt, m_cnt, m_cnt4);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_counter();
        test_same_cycle_alias();
        test_mispredict_sat();
        test_async_reset();
        test_static_mode();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
